// File: rtl/pmem_line_responder.sv
// pmem_line_responder: services one 128-bit cache line request as a burst of
// eight 16-bit accesses to a word-wide backing SRAM, then pulses pmem_resp.
module pmem_line_responder #(
  parameter int unsigned TURNAROUND = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         busy,
  output logic         sram_req,
  output logic         sram_we,
  output logic [14:0]  sram_addr,
  output logic [15:0]  sram_wdata,
  input  logic [15:0]  sram_rdata,
  input  logic         sram_ack
);

  localparam int unsigned WORDS  = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned LINE_W = 12;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_BURST = 3'd1,
    WR_BURST = 3'd2,
    RESP     = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t                          state_q;
  logic [LINE_W-1:0]               line_q;
  logic [IDX_W-1:0]                idx_q;
  logic [IDX_W-1:0]                idx_nxt;
  logic [CNT_W-1:0]                gap_q;
  logic [WORDS-1:0][WORD_W-1:0]    wbuf_q;
  logic [WORDS-1:0][WORD_W-1:0]    rdata_q;
  logic                            addr_unused;

  // Byte offset within the line carries no information for a line access.
  assign addr_unused = ^pmem_address[3:0];

  // Next word index; only used while idx_q < LAST_IDX, so it never wraps.
  assign idx_nxt = idx_q + IDX_W'(1);

  assign pmem_rdata = rdata_q;

  // Request acceptance, burst sequencing, response pulse and turnaround gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      line_q     <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      wbuf_q     <= '0;
      rdata_q    <= '0;
      pmem_resp  <= 1'b0;
      busy       <= 1'b0;
      sram_req   <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      pmem_resp <= 1'b0;
      case (state_q)
        IDLE: begin
          // A write wins over a simultaneous read; the read is dropped.
          if (pmem_write) begin
            state_q    <= WR_BURST;
            line_q     <= pmem_address[15:4];
            wbuf_q     <= pmem_wdata;
            idx_q      <= '0;
            busy       <= 1'b1;
            sram_req   <= 1'b1;
            sram_we    <= 1'b1;
            sram_addr  <= {pmem_address[15:4], IDX_W'(0)};
            sram_wdata <= pmem_wdata[WORD_W-1:0];
          end else if (pmem_read) begin
            state_q   <= RD_BURST;
            line_q    <= pmem_address[15:4];
            idx_q     <= '0;
            busy      <= 1'b1;
            sram_req  <= 1'b1;
            sram_we   <= 1'b0;
            sram_addr <= {pmem_address[15:4], IDX_W'(0)};
          end
        end

        RD_BURST, WR_BURST: begin
          // Address/we/wdata hold until the SRAM acknowledges the word.
          if (sram_ack) begin
            if (state_q == RD_BURST) begin
              rdata_q[idx_q] <= sram_rdata;
            end
            if (idx_q == LAST_IDX) begin
              state_q   <= RESP;
              sram_req  <= 1'b0;
              sram_we   <= 1'b0;
              pmem_resp <= 1'b1;
            end else begin
              idx_q      <= idx_nxt;
              sram_addr  <= {line_q, idx_nxt};
              sram_wdata <= wbuf_q[idx_nxt];
            end
          end
        end

        RESP: begin
          if (TURNAROUND > 0) begin
            state_q <= GAP;
            gap_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end

        GAP: begin
          // Requests are ignored until the turnaround count elapses.
          if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            gap_q <= gap_q + CNT_W'(1);
          end
        end

        default: begin
          state_q  <= IDLE;
          busy     <= 1'b0;
          sram_req <= 1'b0;
          sram_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Testbench for pmem_line_responder: SRAM model with programmable wait states,
// a line-level reference model and a scoreboard for SRAM accesses and responses.
module tb_pmem_line_responder;

  localparam int unsigned TA = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         busy;
  logic         sram_req;
  logic         sram_we;
  logic [14:0]  sram_addr;
  logic [15:0]  sram_wdata;
  logic [15:0]  sram_rdata;
  logic         sram_ack;

  pmem_line_responder #(.TURNAROUND(TA)) dut (
    .clk(clk), .rst_n(rst_n),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata), .busy(busy),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [14:0] addr;
    logic        we;
    logic [15:0] wdata;
  } acc_t;

  typedef struct {
    int           cyc;
    logic [127:0] rdata;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  rsp_t mon_r;

  // Reference model state: words written so far and the last completed read line.
  logic [15:0]  ref_wr [int];
  logic [127:0] ref_rdata = '0;

  // Initial memory image; line 0x123 holds 0x1000+k in word k.
  function automatic logic [15:0] base_word(input logic [14:0] a);
    if (a[14:3] == 12'h123) return 16'h1000 + 16'(a[2:0]);
    return (16'(a) * 16'd40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_word(input logic [14:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return base_word(a);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM model: ack after wait_cfg wait cycles per word, combinational when zero.
  int          wait_cfg = 0;
  int          wait_cnt;
  bit          mem_ready = 1'b0;
  logic [15:0] mem [0:32767];

  assign sram_ack   = sram_req && (wait_cnt == wait_cfg);
  assign sram_rdata = mem[sram_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (sram_req && !sram_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32768; i++) mem[i] <= base_word(15'(i));
      mem_ready <= 1'b1;
    end else if (rst_n && sram_req && sram_ack && sram_we) begin
      mem[sram_addr] <= sram_wdata;
    end
  end

  // Monitor: SRAM accesses and line responses against the expected queues.
  always @(negedge clk) begin
    if (rst_n && sram_req) begin
      if (acc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sram_req: addr %0h with no access expected", sram_addr);
      end else begin
        chk("sram_addr", 128'(sram_addr), 128'(acc_q[0].addr));
        chk("sram_we", 128'(sram_we), 128'(acc_q[0].we));
        if (acc_q[0].we) chk("sram_wdata", 128'(sram_wdata), 128'(acc_q[0].wdata));
        if (sram_ack) void'(acc_q.pop_front());
      end
    end
    if (rst_n && pmem_resp) begin
      chk("sram_req_in_resp", 128'(sram_req), 128'(0));
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp at cycle %0d, required none", cyc);
      end else begin
        mon_r = rsp_q.pop_front();
        chk("resp_cycle", 128'(cyc), 128'(mon_r.cyc));
        chk("pmem_rdata", pmem_rdata, mon_r.rdata);
      end
    end
  end

  // Issue one request at a negedge, record expectations, wait for pmem_resp.
  task automatic do_txn(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [127:0] wd, input int w, input bit keep);
    int           c;
    int           n;
    logic [127:0] exp_line;
    acc_t         a;
    rsp_t         r;
    exp_line     = '0;
    wait_cfg     = w;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    c = cyc;
    for (int k = 0; k < 8; k++) begin
      a.addr  = {addr[15:4], 3'(k)};
      a.we    = wr;
      a.wdata = wd[16*k +: 16];
      acc_q.push_back(a);
      if (wr) ref_wr[int'(a.addr)] = a.wdata;
      else exp_line[16*k +: 16] = ref_word(a.addr);
    end
    if (!wr) ref_rdata = exp_line;
    r.cyc   = c + 9 + 8 * w;
    r.rdata = ref_rdata;
    rsp_q.push_back(r);
    n = 0;
    while (!pmem_resp && n < 80) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        pmem_address = 16'($urandom);
        pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (!pmem_resp) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: no resp within %0d cycles of cycle %0d", n, c);
    end
    if (!keep) begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
    end
  endtask

  task automatic gap_idle(input int extra);
    repeat (TA + 1 + extra) @(negedge clk);
  endtask

  localparam logic [127:0] LINE_123 = 128'h1007_1006_1005_1004_1003_1002_1001_1000;
  localparam logic [127:0] WLINE    = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;

  initial begin
    acc_t a;
    int   c;
    int   mode;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;

    repeat (3) @(negedge clk);
    chk("rst_resp", 128'(pmem_resp), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_sram_req", 128'(sram_req), 128'(0));
    chk("rst_sram_we", 128'(sram_we), 128'(0));
    chk("rst_sram_addr", 128'(sram_addr), 128'(0));
    chk("rst_sram_wdata", 128'(sram_wdata), 128'(0));
    chk("rst_rdata", pmem_rdata, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait read of line 0x123.
    do_txn(1'b1, 1'b0, 16'h1234, '0, 0, 1'b0);
    chk("read_line_123", pmem_rdata, LINE_123);
    gap_idle(0);

    // Write leaves pmem_rdata untouched.
    do_txn(1'b0, 1'b1, 16'h0040, WLINE, 0, 1'b0);
    chk("rdata_kept_on_write", pmem_rdata, LINE_123);
    gap_idle(1);

    // Read back with two wait cycles per word.
    do_txn(1'b1, 1'b0, 16'h0047, '0, 2, 1'b0);
    chk("readback_written", pmem_rdata, WLINE);
    gap_idle(0);

    // Both requests high: write wins; one-extra-cycle hold is ignored.
    do_txn(1'b1, 1'b1, 16'h0050, {4{32'hCAFE_F00D}}, 0, 1'b1);
    @(negedge clk);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_one_ignored_busy", 128'(busy), 128'(0));
    chk("hold_one_ignored_req", 128'(sram_req), 128'(0));

    // Request still high on IDLE re-entry starts a new transaction.
    do_txn(1'b1, 1'b1, 16'h0060, {4{32'h1234_5678}}, 1, 1'b1);
    repeat (TA + 1) @(negedge clk);
    do_txn(1'b1, 1'b1, 16'h0060, {4{32'h1234_5678}}, 0, 1'b0);
    gap_idle(0);

    // Reset during word 4 of a read aborts the burst with no response.
    wait_cfg     = 0;
    pmem_read    = 1'b1;
    pmem_address = 16'h1230;
    for (int k = 0; k < 8; k++) begin
      a.addr  = {12'h123, 3'(k)};
      a.we    = 1'b0;
      a.wdata = '0;
      acc_q.push_back(a);
    end
    c = cyc;
    repeat (5) @(negedge clk);
    chk("word4_cycle", 128'(cyc), 128'(c + 5));
    rst_n     = 1'b0;
    pmem_read = 1'b0;
    #1;
    chk("abort_sram_req", 128'(sram_req), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_rdata", pmem_rdata, 128'(0));
    chk("abort_resp", 128'(pmem_resp), 128'(0));
    acc_q.delete();
    ref_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Normal read after the aborted one.
    do_txn(1'b1, 1'b0, 16'h004F, '0, 0, 1'b0);
    gap_idle(0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      mode = int'($urandom_range(0, 2));
      do_txn(mode != 1, mode != 0, 16'($urandom),
             {$urandom, $urandom, $urandom, $urandom},
             int'($urandom_range(0, 2)), 1'b0);
      gap_idle(int'($urandom_range(0, 2)));
    end

    repeat (5) @(negedge clk);
    chk("rsp_q_drained", 128'(rsp_q.size()), 128'(0));
    chk("acc_q_drained", 128'(acc_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
